// File: rtl/mc_io_bank.sv
// mc_io_bank: addressable bit-serial I/O bank for the MC14500B core.
// Each input pin passes through a synchroniser and a debounce filter. The
// core reads one filtered bit per cycle by address. Each output pin is held
// in its own latch, and the core writes one latch per cycle by address.
// Optional build macro: MC_IO_OUT_READBACK_EN maps the output latches into
// the read address space directly above the inputs.
module mc_io_bank #(
    parameter int INPUT_SIZE      = 8,
    parameter int OUTPUT_SIZE     = 8,
    parameter int IO_ADDR_WIDTH   = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [INPUT_SIZE-1:0]    input_pins,
    input  logic [IO_ADDR_WIDTH-1:0] rd_addr,
    output logic                     rd_data,
    input  logic                     wr_en,
    input  logic [IO_ADDR_WIDTH-1:0] wr_addr,
    input  logic                     wr_data,
    input  logic                     out_clear,
    output logic [OUTPUT_SIZE-1:0]   output_pins,
    output logic                     in_change
);

    localparam int ADDR_SPAN = 2 ** IO_ADDR_WIDTH;
    localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets that would alias addresses or break the filter.
    generate
        if (INPUT_SIZE < 1 || INPUT_SIZE > ADDR_SPAN)
            $error("mc_io_bank: INPUT_SIZE out of range");
        if (OUTPUT_SIZE < 1 || OUTPUT_SIZE > ADDR_SPAN)
            $error("mc_io_bank: OUTPUT_SIZE out of range");
        if (SYNC_STAGES < 2)
            $error("mc_io_bank: SYNC_STAGES must be at least 2");
        if (DEBOUNCE_CYCLES < 1)
            $error("mc_io_bank: DEBOUNCE_CYCLES must be at least 1");
`ifdef MC_IO_OUT_READBACK_EN
        if (INPUT_SIZE + OUTPUT_SIZE > ADDR_SPAN)
            $error("mc_io_bank: inputs plus read-back outputs exceed the address space");
`endif
    endgenerate

    logic [INPUT_SIZE-1:0]  synced;
    logic [INPUT_SIZE-1:0]  filtered;
    logic [INPUT_SIZE-1:0]  filtered_prev_reg;
    logic                   in_change_reg;
    logic [OUTPUT_SIZE-1:0] out_reg;
    logic [OUTPUT_SIZE-1:0] out_next;
    logic [ADDR_SPAN-1:0]   rd_vec;

    genvar gi;

    // Per-channel input path: synchroniser chain, then debounce filter.
    generate
        for (gi = 0; gi < INPUT_SIZE; gi++) begin : g_in
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CNT_W-1:0]       cnt_reg;
            logic                   filt_reg;

            // Shift the raw pin through the synchroniser; bit 0 is nearest the pin.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], input_pins[gi]};
                end
            end

            assign synced[gi] = sync_reg[SYNC_STAGES-1];

            // Count consecutive samples that disagree with the filtered value;
            // adopt the new value only after DEBOUNCE_CYCLES of them in a row.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg  <= '0;
                    filt_reg <= 1'b0;
                end else if (synced[gi] == filt_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    filt_reg <= synced[gi];
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign filtered[gi] = filt_reg;
        end
    endgenerate

    // Change detector: a filtered update at one edge yields a single pulse
    // registered at the following edge, however many channels changed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filtered_prev_reg <= '0;
            in_change_reg     <= 1'b0;
        end else begin
            filtered_prev_reg <= filtered;
            in_change_reg     <= (filtered != filtered_prev_reg);
        end
    end

    assign in_change = in_change_reg;

    // Per-bit write decode: an address beyond OUTPUT_SIZE matches no bit,
    // so such writes fall away without a separate range compare.
    generate
        for (gi = 0; gi < OUTPUT_SIZE; gi++) begin : g_out
            assign out_next[gi] = (wr_en && (wr_addr == IO_ADDR_WIDTH'(gi))) ? wr_data : out_reg[gi];
        end
    endgenerate

    // Output latches: clear wins over a same-cycle write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_reg <= '0;
        end else if (out_clear) begin
            out_reg <= '0;
        end else begin
            out_reg <= out_next;
        end
    end

    assign output_pins = out_reg;

    // Flatten the readable address space into one vector, so the read is a
    // plain index by rd_addr; unmapped addresses read 0.
    generate
        for (gi = 0; gi < ADDR_SPAN; gi++) begin : g_rd
            if (gi < INPUT_SIZE) begin : g_filt
                assign rd_vec[gi] = filtered[gi];
            end
`ifdef MC_IO_OUT_READBACK_EN
            else if (gi < INPUT_SIZE + OUTPUT_SIZE) begin : g_back
                assign rd_vec[gi] = out_reg[gi-INPUT_SIZE];
            end
`endif
            else begin : g_zero
                assign rd_vec[gi] = 1'b0;
            end
        end
    endgenerate

    assign rd_data = rd_vec[rd_addr];

endmodule

// File: tb/tb_mc_io_bank.sv
// tb_mc_io_bank: scoreboard bench for mc_io_bank with default parameters.
// The reference model keeps a short history of sampled pin vectors and flips
// a filtered bit when its last DEBOUNCE_CYCLES synchronised samples all
// disagree with it. Define MC_IO_OUT_READBACK_EN to test the read-back build.
module tb_mc_io_bank;

    localparam int IN_N  = 8;
    localparam int OUT_N = 8;
    localparam int AW    = 4;
    localparam int SS    = 2;
    localparam int DB    = 4;

`ifdef MC_IO_OUT_READBACK_EN
    localparam logic RB_BIT7 = 1'b1;
`else
    localparam logic RB_BIT7 = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [IN_N-1:0] input_pins = '0;
    logic [AW-1:0]   rd_addr = '0;
    logic            rd_data;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic            wr_data = 1'b0;
    logic            out_clear = 1'b0;
    logic [OUT_N-1:0] output_pins;
    logic            in_change;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic             rd;
        logic             chg;
        logic [OUT_N-1:0] outp;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state.
    logic [IN_N-1:0]  m_filt;
    logic [OUT_N-1:0] m_out;
    logic             m_chg;
    logic             m_pending;
    logic [IN_N-1:0]  m_hist[$];

    mc_io_bank #(
        .INPUT_SIZE     (IN_N),
        .OUTPUT_SIZE    (OUT_N),
        .IO_ADDR_WIDTH  (AW),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .input_pins (input_pins),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .out_clear  (out_clear),
        .output_pins(output_pins),
        .in_change  (in_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_filt    = '0;
        m_out     = '0;
        m_chg     = 1'b0;
        m_pending = 1'b0;
        m_hist.delete();
        for (int k = 0; k < SS + DB; k++) m_hist.push_back('0);
    endtask

    // Advance the model by one rising edge using the inputs held across it.
    task automatic model_edge();
        logic [IN_N-1:0] flip;
        logic            all_diff;
        if (!reset) return;
        flip = '0;
        m_hist.push_back(input_pins);
        void'(m_hist.pop_front());
        // Oldest DB entries are the synchronised samples seen by the filter.
        for (int i = 0; i < IN_N; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++)
                if (m_hist[j][i] == m_filt[i]) all_diff = 1'b0;
            flip[i] = all_diff;
        end
        m_chg     = m_pending;
        m_pending = (flip != '0);
        m_filt    = m_filt ^ flip;
        if (out_clear) m_out = '0;
        else if (wr_en && int'(wr_addr) < OUT_N) m_out[int'(wr_addr)] = wr_data;
    endtask

    function automatic logic exp_rd();
        int a;
        a = int'(rd_addr);
        if (a < IN_N) return m_filt[a];
`ifdef MC_IO_OUT_READBACK_EN
        if (a < IN_N + OUT_N) return m_out[a-IN_N];
`endif
        return 1'b0;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.rd   = exp_rd();
        e.chg  = m_chg;
        e.outp = m_out;
        exp_q.push_back(e);
    endtask

    // One clock: wait for the edge, update the model, then drive new inputs.
    task automatic cyc(input logic [IN_N-1:0] p, input logic [AW-1:0] ra, input logic we,
                       input logic [AW-1:0] wa, input logic wd, input logic clr);
        @(posedge clk);
        #1;
        model_edge();
        input_pins = p;
        rd_addr    = ra;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        out_clear  = clr;
        push_exp();
    endtask

    // Assert reset just after an edge, hold it across n edges, then release.
    task automatic pulse_reset(input int n);
        @(posedge clk);
        #1;
        model_edge();
        reset = 1'b0;
        model_reset();
        push_exp();
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            model_edge();
            if (k == n) reset = 1'b1;
            push_exp();
        end
    endtask

    // Monitor: one expected response per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_rd_data", 32'(rd_data), 32'(mon_e.rd));
            chk("sb_in_change", 32'(in_change), 32'(mon_e.chg));
            chk("sb_output_pins", 32'(output_pins), 32'(mon_e.outp));
        end
    end

    initial begin
        int lat;
        int first_chg;
        int n_chg;
        int seen_rd;
        logic [IN_N-1:0] pins;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        push_exp();

        // Reset state at every read address.
        for (int a = 0; a < 16; a++) cyc('0, AW'(a), 1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("reset_output_pins", 32'(output_pins), 32'h00);
        chk("reset_in_change", 32'(in_change), 32'h0);

        // Clean step on pin 3.
        cyc(8'h08, 4'd3, 1'b0, '0, 1'b0, 1'b0);
        lat = 0; first_chg = 0; n_chg = 0;
        for (int e = 1; e <= 12; e++) begin
            cyc(8'h08, 4'd3, 1'b0, '0, 1'b0, 1'b0);
            if (rd_data && lat == 0) lat = e;
            if (in_change) begin
                n_chg++;
                if (first_chg == 0) first_chg = e;
            end
        end
        chk("step_latency", 32'(lat), 32'd6);
        chk("step_in_change_edge", 32'(first_chg), 32'd7);
        chk("step_in_change_count", 32'(n_chg), 32'd1);

        // Short glitch on pin 5 must be filtered out.
        n_chg = 0; seen_rd = 0;
        for (int e = 0; e < 3; e++) cyc(8'h28, 4'd5, 1'b0, '0, 1'b0, 1'b0);
        for (int e = 0; e < 10; e++) begin
            cyc(8'h08, 4'd5, 1'b0, '0, 1'b0, 1'b0);
            if (in_change) n_chg++;
            if (rd_data) seen_rd++;
        end
        chk("glitch_in_change", 32'(n_chg), 32'd0);
        chk("glitch_rd_data", 32'(seen_rd), 32'd0);

        // Output writes, out-of-range write, clear beating a write.
        cyc(8'h08, 4'd0, 1'b1, 4'd2, 1'b1, 1'b0);
        cyc(8'h08, 4'd0, 1'b1, 4'd7, 1'b1, 1'b0);
        chk("wr_bit2", 32'(output_pins), 32'h04);
        cyc(8'h08, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0);
        chk("wr_bit7", 32'(output_pins), 32'h84);
        cyc(8'h08, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1);
        chk("wr_out_of_range", 32'(output_pins), 32'h84);
        cyc(8'h08, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("clear_beats_write", 32'(output_pins), 32'h00);

        // Read-back region.
        cyc(8'h08, 4'd0, 1'b1, 4'd2, 1'b1, 1'b0);
        cyc(8'h08, 4'd0, 1'b1, 4'd7, 1'b1, 1'b0);
        cyc(8'h08, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        chk("readback_addr15", 32'(rd_data), 32'(RB_BIT7));
        cyc(8'h08, 4'd8, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        chk("readback_addr8", 32'(rd_data), 32'h0);

        // Reset in the middle of a debounce, then relatch from scratch.
        cyc(8'hFF, 4'd0, 1'b0, '0, 1'b0, 1'b0);
        cyc(8'hFF, 4'd0, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        model_edge();
        reset = 1'b0;
        model_reset();
        push_exp();
        #1;
        chk("midreset_output_pins", 32'(output_pins), 32'h00);
        chk("midreset_rd_data", 32'(rd_data), 32'h0);
        chk("midreset_in_change", 32'(in_change), 32'h0);
        @(posedge clk);
        #1;
        model_edge();
        reset = 1'b1;
        push_exp();
        lat = 0;
        for (int e = 1; e <= 10; e++) begin
            cyc(8'hFF, 4'd0, 1'b0, '0, 1'b0, 1'b0);
            if (rd_data && lat == 0) lat = e;
        end
        chk("post_reset_latency", 32'(lat), 32'd6);

        // Randomised traffic against the model.
        pins = input_pins;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(399) == 0) begin
                pulse_reset(int'($urandom_range(1, 3)));
            end else begin
                for (int i = 0; i < IN_N; i++)
                    if ($urandom_range(7) == 0) pins[i] = ~pins[i];
                cyc(pins, AW'($urandom_range(15)), 1'($urandom_range(1)),
                    AW'($urandom_range(15)), 1'($urandom_range(1)),
                    1'($urandom_range(31) == 0));
            end
        end

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_io_bank.md
Name: mc_io_bank

Overview:
Addressable bit-serial I/O bank between the MC14500B core and the board pins. Synchronises and debounces every input pin, and holds every output pin in an individually written latch. The core reads one filtered input bit per cycle by address and writes one output bit per cycle by address. Parametrised successor to the fixed 8-in/8-out pin interface, generalised in channel count and filter depth.

Parameters:
INPUT_SIZE, 8, number of input pins (1..2**IO_ADDR_WIDTH)
OUTPUT_SIZE, 8, number of output pins (1..2**IO_ADDR_WIDTH)
IO_ADDR_WIDTH, 4, width of the read/write address buses
SYNC_STAGES, 2, synchroniser flops per input (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before the filtered value changes (>=1)

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
input_pins  in  INPUT_SIZE  raw asynchronous board inputs
rd_addr  in  IO_ADDR_WIDTH  input bit select
rd_data  out  1  selected filtered input bit (combinational from registers)
wr_en  in  1  output latch write strobe
wr_addr  in  IO_ADDR_WIDTH  output bit select
wr_data  in  1  value written to the selected output latch
out_clear  in  1  synchronous clear of all output latches
output_pins  out  OUTPUT_SIZE  registered output latches driving the board
in_change  out  1  one-cycle pulse when any filtered input bit changes

Behaviour:
- Reset (reset=0, asynchronous): sync chains, filtered[], debounce counters, output_pins, in_change all 0. rd_data therefore reads 0. Reset mid-operation discards pending debounce counts and latched outputs immediately.
- Sync: per input, a SYNC_STAGES-deep flop chain. synced[i] is the last stage.
- Debounce, per channel i, counter cnt[i] of width $clog2(DEBOUNCE_CYCLES+1):
  - If synced[i]==filtered[i]: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: filtered[i]<=synced[i], cnt<=0.
  - Else: cnt<=cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synced samples never reaches filtered. Any return to the filtered value restarts the count.
- Latency: a clean pin step appears on filtered/rd_data SYNC_STAGES+DEBOUNCE_CYCLES rising edges later (6 with defaults).
- in_change: registered. It is 1 for exactly the cycle after any filtered bit updates. Simultaneous changes on several channels give a single pulse.
- Read: rd_data = filtered[rd_addr] when rd_addr<INPUT_SIZE; otherwise 0 (base build). No read side effects.
- Write, priority order at each edge:
  - out_clear=1 sets all output_pins to 0, and a same-cycle write is dropped.
  - Else if wr_en=1 and wr_addr<OUTPUT_SIZE, output_pins[wr_addr]<=wr_data. Only one bit changes; the others hold.
  - wr_en with wr_addr>=OUTPUT_SIZE is ignored.
- Written value visible on output_pins one edge after the strobe.
- Read and write are independent. Same-cycle read/write never interact in the base build.

Optional Feature:
MC_IO_OUT_READBACK_EN
- Defined: rd_addr in INPUT_SIZE..INPUT_SIZE+OUTPUT_SIZE-1 returns output_pins[rd_addr-INPUT_SIZE], and addresses beyond that return 0. INPUT_SIZE+OUTPUT_SIZE must be <=2**IO_ADDR_WIDTH, checked by an elaboration-time assertion. A same-cycle write to the read-back bit returns the pre-write (registered) value.
- Undefined: all rd_addr>=INPUT_SIZE read 0.

Test Plan:
- Reset release, all inputs 0 -> output_pins=8'h00, rd_data=0 at every rd_addr, in_change=0.
- input_pins[3] steps 0->1 at edge N, rd_addr=3 -> rd_data=1 first at edge N+6; in_change=1 for one cycle at N+7 only.
- input_pins[5] glitches high for 3 synced cycles (<4) -> rd_data at rd_addr=5 stays 0 and in_change never pulses.
- wr_en=1, wr_addr=2, wr_data=1, then wr_addr=7, wr_data=1 -> output_pins=8'h04 then 8'h84. Then wr_addr=9 -> 8'h84 unchanged. Then out_clear=1 with wr_en=1, wr_addr=0 -> 8'h00.
- Drive input_pins=8'hFF, then assert reset for 1 cycle at edge N+3 -> all outputs 0 immediately. After release, rd_data for rd_addr=0 goes to 1 only 6 edges after release.
- MC_IO_OUT_READBACK_EN defined, output_pins=8'h84, rd_addr=15 -> rd_data=1 (bit 7); rd_addr=8 -> 0. Undefined, rd_addr=15 -> 0.
